// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchronizer, down-counting baud timer, sticky rdy/overrun.
// Optional build macro UART_RX_MAJORITY_EN: 2-of-3 majority vote around every sample point.
module uart_rx_core #(
  parameter int BAUD_DIV = 2604
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       RX,
  input  logic       clr_rdy,
  output logic [7:0] rx_data,
  output logic       rdy,
  output logic       framing_err,
  output logic       overrun
);

  localparam int CW = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] HALF_LD = CW'(BAUD_DIV / 2 - 1);
`ifdef UART_RX_MAJORITY_EN
  // the decision lands one cycle after count 0, so the reload is one shorter
  localparam logic [CW-1:0] BIT_LD = CW'(BAUD_DIV - 2);
`else
  localparam logic [CW-1:0] BIT_LD = CW'(BAUD_DIV - 1);
`endif

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic          rx_m, rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;
  logic          armed, arm_nx;
  logic          tick, bit_val;
  logic          load_half, load_bit, shift_en, bit_clr, good_stop, bad_stop;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic late, s1, s0;

  assign tick    = late;
  assign bit_val = (s1 & s0) | (s1 & rx_s) | (s0 & rx_s);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      late <= 1'b0;
      s1   <= 1'b1;
      s0   <= 1'b1;
    end else begin
      late <= (state != IDLE) && (cnt == '0) && !late;
      if (cnt == CW'(1)) s1 <= rx_s;
      if ((cnt == '0) && !late) s0 <= rx_s;
    end
  end
`else
  assign tick    = (cnt == '0);
  assign bit_val = rx_s;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    arm_nx    = 1'b0;
    load_half = 1'b0;
    load_bit  = 1'b0;
    shift_en  = 1'b0;
    bit_clr   = 1'b0;
    good_stop = 1'b0;
    bad_stop  = 1'b0;
    case (state)
      IDLE: begin
        // a start is only accepted after the line has been seen high
        arm_nx = armed | rx_s;
        if (armed && !rx_s) begin
          state_nx  = START;
          load_half = 1'b1;
          arm_nx    = 1'b0;
        end
      end
      START: begin
        if (tick) begin
          if (bit_val) begin
            state_nx = IDLE;
          end else begin
            state_nx = DATA;
            load_bit = 1'b1;
            bit_clr  = 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_en = 1'b1;
          load_bit = 1'b1;
          if (bit_cnt == 3'd7) state_nx = STOP;
        end
      end
      STOP: begin
        if (tick) begin
          state_nx  = IDLE;
          good_stop = bit_val;
          bad_stop  = !bit_val;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load_half) begin
      cnt <= HALF_LD;
    end else if (load_bit) begin
      cnt <= BIT_LD;
    end else if (cnt != '0) begin
      cnt <= cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      armed       <= 1'b0;
      bit_cnt     <= 3'd0;
      shift       <= 8'h00;
      rx_data     <= 8'h00;
      rdy         <= 1'b0;
      overrun     <= 1'b0;
      framing_err <= 1'b0;
    end else begin
      armed <= arm_nx;
      if (bit_clr)       bit_cnt <= 3'd0;
      else if (shift_en) bit_cnt <= bit_cnt + 3'd1;
      if (shift_en) shift <= {bit_val, shift[7:1]};
      if (good_stop) rx_data <= shift;
      framing_err <= bad_stop;
      // set wins over a coincident clear
      rdy     <= good_stop | (rdy & ~clr_rdy);
      overrun <= (good_stop & rdy) | (overrun & ~clr_rdy);
    end
  end

endmodule
